// File: rtl/odometer_scan_display.sv
// odometer_scan_display
//   Converts a binary mileage count to BCD with a sequential double-dabble
//   engine. It then time-multiplexes DIGITS seven-segment digits onto one
//   shared segment bus, with a one-hot digit enable for each digit.
//
// Optional build macro:
//   ODO_LZ_BLANK_EN - when defined, leading zero digits are blanked.
//                     Digit 0 is never blanked.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   power_now in   1 = display lit, 0 = display dark (counters keep running)
//   value     in   binary mileage [BIN_W-1:0]
//   seg_out   out  segments {a,b,c,d,e,f,g,dp}, active high (dp always 0)
//   digit_en  out  one-hot digit enable; bit 0 = least significant digit
//   busy      out  conversion in progress
//   overflow  out  displayed value saturated to all 9s
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a new value, or for a pending re-conversion
// S_SHIFT | BIN_W double-dabble iterations, one per clock
// S_LATCH | copy the BCD result (or all 9s) to the display register

module odometer_scan_display #(
  parameter int BIN_W    = 27,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              power_now,
  input  logic [BIN_W-1:0]  value,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] digit_en,
  output logic              busy,
  output logic              overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] max_display(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_display(DIGITS);

  // Add 3 to every nibble >= 5 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++)
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t             r_state, w_state_nxt;
  logic               w_capture, w_latch;
  logic [BIN_W-1:0]   r_cap, r_last, r_shift;
  logic               r_pending;
  logic [BCD_W-1:0]   r_bcd, r_disp;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf, r_busy;
  logic               w_too_big;
  logic [DIV_W-1:0]   r_div;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         w_digit;
  logic               w_blank;
  logic [7:0]         r_seg;
  logic [DIGITS-1:0]  r_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((value != r_last) || r_pending) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == '0) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_latch     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_too_big = (64'(r_cap) > MAX_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap     <= '0;
      r_last    <= '0;
      r_shift   <= '0;
      r_pending <= 1'b0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_disp    <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_cap     <= value;
        r_shift   <= value;
        r_bcd     <= '0;
        r_cnt     <= CNT_W'(BIN_W - 1);
        r_pending <= 1'b0;
        r_busy    <= 1'b1;
      end else if ((r_state != S_IDLE) && (value != r_cap)) begin
        // Finish the running conversion untouched; redo it afterwards.
        r_pending <= 1'b1;
      end

      if (r_state == S_SHIFT) begin
        // The truncating cast drops the top bit of the adjusted BCD
        // vector. That bit only matters for values that saturate anyway.
        r_bcd   <= BCD_W'({dd_adjust(r_bcd), r_shift[BIN_W-1]});
        r_shift <= r_shift << 1;
        r_cnt   <= r_cnt - CNT_W'(1);
      end

      if (w_latch) begin
        r_last <= r_cap;
        r_busy <= 1'b0;
        if (w_too_big) begin
          r_disp <= {DIGITS{4'h9}};
          r_ovf  <= 1'b1;
        end else begin
          r_disp <= r_bcd;
          r_ovf  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (r_idx == IDX_W'(i)) w_digit = r_disp[4*i +: 4];
  end

`ifdef ODO_LZ_BLANK_EN
  // A digit is blanked when it and every higher digit are zero.
  logic [DIGITS-1:0] w_lead_zero;
  always_comb begin
    w_lead_zero = '0;
    w_lead_zero[DIGITS-1] = (r_disp[BCD_W-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--)
      w_lead_zero[i] = w_lead_zero[i+1] && (r_disp[4*i +: 4] == 4'd0);
  end

  always_comb begin
    w_blank = 1'b0;
    for (int i = 1; i < DIGITS; i++)
      if (r_idx == IDX_W'(i)) w_blank = w_lead_zero[i];
  end
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_en  <= '0;
    end else if (!power_now) begin
      r_seg <= '0;
      r_en  <= '0;
    end else begin
      r_en  <= DIGITS'(1) << r_idx;
      r_seg <= w_blank ? 8'h00 : seg7(w_digit);
    end
  end

  assign seg_out  = r_seg;
  assign digit_en = r_en;
  assign busy     = r_busy;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_odometer_scan_display.sv
module tb_odometer_scan_display;

  localparam int BIN_W    = 27;
  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam longint MAXV = 64'd99999999;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              power_now = 1'b0;
  logic [BIN_W-1:0]  value = '0;
  logic [7:0]        seg_out;
  logic [DIGITS-1:0] digit_en;
  logic              busy;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  longint exp_q[$];
  longint shown     = 0;
  bit     shown_ovf = 1'b0;
  int     edges     = 0;
  bit     pw_edge   = 1'b0;
  int     busy_len  = 0;
  bit     busy_prev = 1'b0;
  int     done_cnt  = 0;

  always #5 clk = ~clk;

  odometer_scan_display #(
    .BIN_W   (BIN_W),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .power_now(power_now),
    .value    (value),
    .seg_out  (seg_out),
    .digit_en (digit_en),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hFC;
      1: return 8'h60;
      2: return 8'hDA;
      3: return 8'hF2;
      4: return 8'h66;
      5: return 8'hB6;
      6: return 8'hBE;
      7: return 8'hE0;
      8: return 8'hFE;
      9: return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  // Expected segment pattern for decimal position i of number v.
  function automatic logic [7:0] exp_seg(input longint v, input int i);
    longint p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
`ifdef ODO_LZ_BLANK_EN
    if (i > 0 && (v / p) == 0) return 8'h00;
`endif
    return seg_code(int'((v / p) % 10));
  endfunction

  // Count clock edges seen since reset release, and the power level
  // that each edge sampled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges   = 0;
      pw_edge = 1'b0;
    end else begin
      edges++;
      pw_edge = power_now;
    end
  end

  // Monitor: compares outputs against the model on every cycle. It pops
  // the next expected value each time a conversion finishes.
  always @(negedge clk) begin
    int     idx;
    longint v;
    if (!rst_n) begin
      exp_q.delete();
      shown     = 0;
      shown_ovf = 1'b0;
      busy_len  = 0;
      busy_prev = 1'b0;
    end else begin
      if (edges == 0 || !pw_edge) begin
        check("dark_seg", seg_out, 0);
        check("dark_en", digit_en, 0);
      end else begin
        idx = ((edges - 1) / SCAN_DIV) % DIGITS;
        check("digit_en", digit_en, longint'(1) << idx);
        check("seg_out", seg_out, exp_seg(shown, idx));
      end
      if (busy) busy_len++;
      if (busy_prev && !busy) begin
        check("busy_len", busy_len, BIN_W + 1);
        busy_len = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_conversion: got a completion expected none at %0t", $time);
        end else begin
          v = exp_q.pop_front();
          if (v > MAXV) begin
            shown     = MAXV;
            shown_ovf = 1'b1;
          end else begin
            shown     = v;
            shown_ovf = 1'b0;
          end
          done_cnt++;
        end
      end
      check("overflow", overflow, shown_ovf);
      busy_prev = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_value(input longint v);
    value = BIN_W'(v);
    exp_q.push_back(v);
  endtask

  task automatic wait_done(input string name, input int target, output int cyc);
    cyc = 0;
    while (done_cnt < target && cyc < 300) begin
      tick(1);
      cyc++;
    end
    check(name, (done_cnt >= target), 1);
  endtask

  task automatic wait_busy(input string name);
    int c;
    c = 0;
    while (!busy && c < 20) begin
      tick(1);
      c++;
    end
    check(name, busy, 1);
  endtask

  task automatic show(input string name, input longint v);
    int c;
    set_value(v);
    wait_done(name, done_cnt + 1, c);
    tick(DIGITS * SCAN_DIV + 2);
  endtask

  initial begin
    int     c;
    int     tgt;
    longint prev;
    longint v;

    #2;
    check("rst_seg", seg_out, 0);
    check("rst_en", digit_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);

    @(posedge clk);
    #1;
    power_now = 1'b1;
    rst_n     = 1'b1;
    tick(DIGITS * SCAN_DIV + 8);

    show("done_12345678", 12345678);
    show("done_overflow", 100000000);
    show("done_5", 5);
    show("done_305", 305);

    // A change three cycles into SHIFT must finish the first value, then
    // convert the new one, with nothing in between.
    set_value(42);
    tgt = done_cnt + 2;
    wait_busy("busy_42");
    tick(3);
    set_value(97);
    c = 0;
    while (done_cnt < tgt && c < 300) begin
      tick(1);
      c++;
    end
    check("pending_latency_ok", (c + 4 <= 2 * (BIN_W + 2) + 1), 1);
    tick(DIGITS * SCAN_DIV + 2);

    power_now = 1'b0;
    tick(20);
    check("pwr_off_seg", seg_out, 0);
    check("pwr_off_en", digit_en, 0);
    power_now = 1'b1;
    tick(DIGITS * SCAN_DIV + 2);

    prev = 97;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 3) == 0) v = longint'($urandom_range(0, (1 << BIN_W) - 1));
      else                           v = longint'($urandom_range(0, 99999999));
      if (v == prev) v = (v + 1) % 100000000;
      prev = v;
      show("done_rand", v);
    end

    // Reset during SHIFT must abort the conversion and dark the outputs.
    set_value(777);
    wait_busy("busy_777");
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midrst_seg", seg_out, 0);
    check("midrst_en", digit_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", overflow, 0);
    value = '0;
    tick(2);
    rst_n = 1'b1;
    tick(DIGITS * SCAN_DIV + 4);
    check("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
